tiny_dnn_seq: RTL and testbench
===============================

Name: tiny_dnn_seq

Overview:
Host-side initiator that drives the tiny_dnn accelerator's write/init/exec/a/d command interface and collects its fp32 results from x.
- Converts two simple valid/ready streams into the accelerator's command sequences.
  - Weight load: fp32 words written to every core's weight RAM.
  - Inference run: init, stream of F_SIZE activation words, pipeline drain, readback of F_NUM results.
- Sits between the DMA/host stream fabric and the accelerator top.

Parameters:
- F_NUM, 16, number of accelerator cores/filters (results per run)
- F_SIZE, 512, weights per core; activations per run
- AW, 13, accelerator address width; equals log2(F_NUM*F_SIZE)
- DRAIN, 2, idle cycles after the last exec before readback (core input latch plus FMA register)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; accepted only in IDLE
- op  in  1  0 = LOAD weights, 1 = RUN inference; sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes
- s_valid  in  1  input stream valid
- s_ready  out  1  input stream ready
- s_data  in  32  fp32 weight or activation word
- m_valid  out  1  result stream valid
- m_ready  in  1  result stream ready
- m_data  out  32  fp32 result word, filter order 0..F_NUM-1
- dnn_write  out  1  to accelerator write
- dnn_init  out  1  to accelerator init
- dnn_exec  out  1  to accelerator exec
- dnn_a  out  AW  to accelerator address
- dnn_d  out  32  to accelerator data (fp32; accelerator truncates to bfloat16)
- dnn_x  in  32  from accelerator result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all counters 0.
  - busy, done, s_ready, m_valid, dnn_write, dnn_init, dnn_exec = 0; dnn_a, dnn_d, m_data = 0.
- At most one of dnn_write/dnn_init/dnn_exec is high in any cycle. All dnn_* outputs are registered.
- States: IDLE, LOAD, INIT, RUN, DRAIN, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE:
  - On start, latch op and go to LOAD (op=0) or INIT (op=1).
  - start while busy is ignored.
- LOAD:
  - s_ready=1. Each handshake issues dnn_write=1, dnn_a=wcnt, dnn_d=s_data in the next cycle, then wcnt++.
  - wcnt[AW-1:log2(F_SIZE)] selects the core; the low bits select the weight.
  - After F_NUM*F_SIZE writes (wcnt wraps to 0): done pulse, return to IDLE.
  - No handshake means dnn_write=0 that cycle.
- INIT:
  - One cycle with dnn_init=1, then RUN. s_ready=0.
- RUN:
  - s_ready=1. Each handshake gives dnn_exec=1, dnn_a=rcnt (0..F_SIZE-1, upper bits 0), dnn_d=s_data; rcnt++.
  - Gaps in s_valid give dnn_exec=0 and dnn_a held. Gaps are legal; the core only accumulates on exec.
  - After F_SIZE handshakes, go to DRAIN.
- DRAIN:
  - DRAIN cycles with all dnn_* strobes low, then RD_ADDR with idx=0.
- RD_ADDR:
  - Drive dnn_a=idx with all strobes low, then RD_WAIT.
- RD_WAIT:
  - The accelerator registers x. Next cycle capture dnn_x into m_data, set m_valid=1, go to RD_OUT.
- RD_OUT:
  - Hold m_data/m_valid until m_ready.
  - On handshake: m_valid=0; idx++.
  - If idx was F_NUM-1: done pulse, IDLE. Otherwise RD_ADDR.
- m_valid is never high outside RD_OUT. s_ready is never high outside LOAD/RUN.
- Reset asserted mid-command aborts immediately.
  - Accelerator weight contents are undefined after an aborted LOAD.
  - The accumulator is re-cleared by the next INIT.
- Counters: wcnt is AW bits; rcnt is log2(F_SIZE) bits; idx is log2(F_NUM) bits; drain count is $clog2(DRAIN+1) bits.

Optional Feature:
- Macro TINY_DNN_SEQ_RELU_EN.
  - Defined: the RD_WAIT capture applies ReLU. If dnn_x[31]=1, m_data=32'h0; otherwise m_data=dnn_x.
  - Undefined: m_data=dnn_x unchanged.
- No latency change either way.

Decomposition:
- Package tiny_dnn_pkg:
  - state enum type seq_state_t
  - localparams F_NUM, F_SIZE, AW, DRAIN defaults
  - OP_LOAD=1'b0, OP_RUN=1'b1
- No sub-module; a single FSM with counters. The optional ReLU is an inline expression.

Test Plan:
- LOAD with all s_data=0x3F800000 (1.0), s_valid always high → exactly 8192 dnn_write pulses with dnn_a 0..8191 in order; one done pulse; busy falls the same cycle.
- RUN with 512 activations 0x40000000 (2.0) after the above load → 16 results on m_data, each 0x44800000 (1024.0); done after the 16th handshake.
- RUN with s_valid toggling 1/0 every cycle → dnn_exec only on handshake cycles, dnn_a contiguous 0..511, results identical to the previous case.
- Readback with m_ready low for 10 cycles on result 3 → m_valid and m_data stable throughout; no dnn_a advance; order preserved.
- Weights 0xBF800000 (-1.0) with activations 2.0 → results 0xC4800000 without the macro; 0x00000000 with TINY_DNN_SEQ_RELU_EN.
- rst_n pulsed low mid-RUN (after 100 activations), then a new RUN command → all outputs 0 during reset; the new run yields the correct results from a fresh INIT; start during busy is ignored.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types and default sizing for the tiny_dnn host-side command sequencer.
// Sizing assumes F_NUM*F_SIZE == 2**AW so the weight-load counter wraps exactly once per load.
package tiny_dnn_pkg;

  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;
  localparam int AW     = 13;
  localparam int DRAIN  = 2;

  localparam int WL = $clog2(F_SIZE);
  localparam int IL = $clog2(F_NUM);
  localparam int DL = $clog2(DRAIN + 1);

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_RUN  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_OUT
  } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq.sv
// Host-side initiator for the tiny_dnn accelerator: turns weight/activation streams into
// write/init/exec command sequences and reads F_NUM results back. Optional ReLU on readback
// is enabled by defining TINY_DNN_SEQ_RELU_EN.
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          dnn_write,
  output logic          dnn_init,
  output logic          dnn_exec,
  output logic [AW-1:0] dnn_a,
  output logic [31:0]   dnn_d,
  input  logic [31:0]   dnn_x
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [WL-1:0] rcnt_q, rcnt_d;
  logic [IL-1:0] idx_q, idx_d;
  logic [DL-1:0] dcnt_q, dcnt_d;

  logic          done_d, m_valid_d, write_d, init_d, exec_d;
  logic [31:0]   m_data_d, d_d;
  logic [AW-1:0] a_d;
  logic [31:0]   rd_word;
  logic          s_hs, m_hs;

  assign busy    = (state_q != ST_IDLE);
  assign s_ready = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = m_valid && m_ready;

`ifdef TINY_DNN_SEQ_RELU_EN
  assign rd_word = dnn_x[31] ? 32'h0 : dnn_x;
`else
  assign rd_word = dnn_x;
`endif

  // Every accelerator-facing output is computed here as a next value and registered below,
  // so the strobes, address and data always change together on the clock edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    done_d    = 1'b0;
    m_valid_d = m_valid;
    m_data_d  = m_data;
    write_d   = 1'b0;
    init_d    = 1'b0;
    exec_d    = 1'b0;
    a_d       = dnn_a;
    d_d       = dnn_d;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_RUN) begin
            state_d = ST_INIT;
            init_d  = 1'b1;
            rcnt_d  = '0;
          end else begin
            state_d = ST_LOAD;
            wcnt_d  = '0;
          end
        end
      end

      ST_LOAD: begin
        if (s_hs) begin
          write_d = 1'b1;
          a_d     = wcnt_q;
          d_d     = s_data;
          wcnt_d  = wcnt_q + AW'(1);
          if (wcnt_q == {AW{1'b1}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_INIT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (s_hs) begin
          exec_d = 1'b1;
          a_d    = AW'(rcnt_q);
          d_d    = s_data;
          rcnt_d = rcnt_q + WL'(1);
          if (rcnt_q == WL'(F_SIZE - 1)) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
      end

      // The first DRAIN cycle still carries the final exec strobe; DRAIN idle cycles follow it.
      ST_DRAIN: begin
        if (dcnt_q == DL'(DRAIN)) begin
          state_d = ST_RD_ADDR;
          dcnt_d  = '0;
          idx_d   = '0;
          a_d     = '0;
        end else begin
          dcnt_d = dcnt_q + DL'(1);
        end
      end

      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
      end

      // dnn_x now reflects the address presented during RD_ADDR.
      ST_RD_WAIT: begin
        m_data_d  = rd_word;
        m_valid_d = 1'b1;
        state_d   = ST_RD_OUT;
      end

      ST_RD_OUT: begin
        if (m_hs) begin
          m_valid_d = 1'b0;
          idx_d     = idx_q + IL'(1);
          if (idx_q == IL'(F_NUM - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_ADDR;
            a_d     = AW'(idx_d);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      idx_q     <= '0;
      dcnt_q    <= '0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      dnn_write <= 1'b0;
      dnn_init  <= 1'b0;
      dnn_exec  <= 1'b0;
      dnn_a     <= '0;
      dnn_d     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values,
      // independent of statement order.
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      done      <= done_d;
      m_valid   <= m_valid_d;
      m_data    <= m_data_d;
      dnn_write <= write_d;
      dnn_init  <= init_d;
      dnn_exec  <= exec_d;
      dnn_a     <= a_d;
      dnn_d     <= d_d;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq: a behavioural accelerator stub plus an integer
// dot-product reference model; values are small integers so fp32/bf16 arithmetic is exact.
module tb_tiny_dnn_seq;
  import tiny_dnn_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic          busy, done;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic          dnn_write, dnn_init, dnn_exec;
  logic [AW-1:0] dnn_a;
  logic [31:0]   dnn_d;
  logic [31:0]   dnn_x = '0;

  int checks = 0;
  int errors = 0;

  tiny_dnn_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .dnn_write(dnn_write), .dnn_init(dnn_init), .dnn_exec(dnn_exec),
    .dnn_a(dnn_a), .dnn_d(dnn_d), .dnn_x(dnn_x)
  );

  always #5 clk = ~clk;

  // fp32 encode/decode for small integers
  function automatic logic [31:0] enc(input int v);
    int mag;
    int e;
    logic [31:0] r;
    r = '0;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) e = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'(mag << (23 - e));
    return r;
  endfunction

  function automatic int dec(input logic [31:0] b);
    int e;
    int m;
    if (b[30:0] == 31'h0) return 0;
    e = int'(b[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = int'({1'b1, b[22:0]}) >> (23 - e);
    return b[31] ? -m : m;
  endfunction

  // Accelerator stub: weight RAM, per-core accumulators, registered result mux
  logic [31:0] w_mem [F_NUM*F_SIZE];
  int acc [F_NUM];

  always @(posedge clk) begin
    if (dnn_write) w_mem[dnn_a] <= dnn_d;
    if (dnn_init) for (int c = 0; c < F_NUM; c++) acc[c] <= 0;
    if (dnn_exec)
      for (int c = 0; c < F_NUM; c++)
        acc[c] <= acc[c] + dec(w_mem[c*F_SIZE + int'(dnn_a[WL-1:0])]) * dec(dnn_d);
    dnn_x <= enc(acc[dnn_a[IL-1:0]]);
  end

  // Event monitor
  logic [AW-1:0] wq [$];
  logic [AW-1:0] eq [$];
  int strobe_err = 0, done_cnt = 0, done_busy_err = 0, idle_err = 0;

  always @(negedge clk) begin
    if (dnn_write) wq.push_back(dnn_a);
    if (dnn_exec) eq.push_back(dnn_a);
    if (int'(dnn_write) + int'(dnn_init) + int'(dnn_exec) > 1) strobe_err++;
    if (done) begin
      done_cnt++;
      if (busy) done_busy_err++;
    end
    if ((m_valid || s_ready) && !busy) idle_err++;
  end

  // Reference model data
  int w_i [F_NUM*F_SIZE];
  int act_i [F_SIZE];
  logic [31:0] stim_q [$];
  logic [31:0] res_q [$];
  int stall_err;

  function automatic logic [31:0] expect_word(input int f);
    int s;
    s = 0;
    for (int i = 0; i < F_SIZE; i++) s += w_i[f*F_SIZE + i] * act_i[i];
`ifdef TINY_DNN_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return enc(s);
  endfunction

  task automatic issue(input logic o);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stream(input int lo, input int hi, input int gap_mode, output bit ok);
    int i;
    int budget;
    i = lo;
    budget = 0;
    ok = 1'b1;
    while (i < hi) begin
      @(negedge clk);
      if (gap_mode == 0)      s_valid = 1'b1;
      else if (gap_mode == 1) s_valid = (budget % 2 == 0);
      else                    s_valid = ($urandom_range(0, 3) != 0);
      s_data = stim_q[i];
      if (s_valid && s_ready) i++;
      budget++;
      if (budget > 4*(hi - lo) + 100) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic collect(input int ready_mode, input int stall_idx, output bit ok);
    int budget;
    int held;
    logic [31:0] snap_d;
    logic [AW-1:0] snap_a;
    budget = 0;
    held = 0;
    snap_d = '0;
    snap_a = '0;
    stall_err = 0;
    ok = 1'b1;
    res_q.delete();
    while (res_q.size() < F_NUM) begin
      @(negedge clk);
      if ((held > 0 && held < 10) || (held == 0 && m_valid && res_q.size() == stall_idx)) begin
        if (held == 0) begin
          snap_d = m_data;
          snap_a = dnn_a;
        end else if (m_valid !== 1'b1 || m_data !== snap_d || dnn_a !== snap_a) begin
          stall_err++;
        end
        m_ready = 1'b0;
        held++;
      end else begin
        m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
      if (m_valid && m_ready) res_q.push_back(m_data);
      budget++;
      if (budget > 3000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic load_weights(input int gap_mode, output bit ok);
    bit ok1, ok2;
    int base;
    base = done_cnt;
    stim_q.delete();
    for (int i = 0; i < F_NUM*F_SIZE; i++) stim_q.push_back(enc(w_i[i]));
    wq.delete();
    issue(OP_LOAD);
    send_stream(0, F_NUM*F_SIZE, gap_mode, ok1);
    wait_done(base + 1, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic run_inf(input int gap_mode, input int ready_mode, input int stall_idx,
                         output bit ok);
    bit ok1, ok2, ok3;
    int base;
    base = done_cnt;
    stim_q.delete();
    for (int i = 0; i < F_SIZE; i++) stim_q.push_back(enc(act_i[i]));
    eq.delete();
    issue(OP_RUN);
    send_stream(0, F_SIZE, gap_mode, ok1);
    collect(ready_mode, stall_idx, ok2);
    wait_done(base + 1, ok3);
    ok = ok1 && ok2 && ok3;
  endtask

  function automatic int count_bad_seq(input int which, input int n);
    int bad;
    bad = 0;
    if (which == 0) begin
      if (wq.size() != n) bad++;
      else for (int i = 0; i < n; i++) if (wq[i] !== AW'(i)) bad++;
    end else begin
      if (eq.size() != n) bad++;
      else for (int i = 0; i < n; i++) if (eq[i] !== AW'(i)) bad++;
    end
    return bad;
  endfunction

  function automatic int count_bad_results();
    int bad;
    bad = 0;
    if (res_q.size() != F_NUM) return F_NUM;
    for (int f = 0; f < F_NUM; f++) if (res_q[f] !== expect_word(f)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    logic [7+AW+64-1:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {busy, done, s_ready, m_valid, dnn_write, dnn_init, dnn_exec, dnn_a, dnn_d, m_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b s_ready=%b, want 0 0", busy, s_ready);
    end
  endtask

  task automatic test_load_ones();
    bit ok;
    int bad;
    int base;
    base = done_cnt;
    for (int i = 0; i < F_NUM*F_SIZE; i++) w_i[i] = 1;
    load_weights(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_ones_timeout: done_cnt=%0d, want %0d", done_cnt, base + 1);
    end
    bad = count_bad_seq(0, F_NUM*F_SIZE);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_ones_addr: %0d bad of %0d writes, want 0 bad", bad, wq.size());
    end
    bad = 0;
    for (int i = 0; i < F_NUM*F_SIZE; i++) if (w_mem[i] !== 32'h3F800000) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_ones_data: %0d words not 3f800000, want 0", bad);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != base + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_ones_done: done pulses=%0d busy=%b, want 1 0", done_cnt - base, busy);
    end
  endtask

  task automatic test_run_twos();
    bit ok;
    int bad;
    for (int i = 0; i < F_SIZE; i++) act_i[i] = 2;
    run_inf(0, 0, -1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_twos_timeout: results=%0d, want %0d", res_q.size(), F_NUM);
    end
    bad = 0;
    if (res_q.size() != F_NUM) bad = F_NUM;
    else foreach (res_q[i]) if (res_q[i] !== 32'h44800000) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_twos_result: %0d bad, first=%h, want 44800000", bad,
               (res_q.size() > 0) ? res_q[0] : 32'hx);
    end
    bad = count_bad_seq(1, F_SIZE);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_twos_exec: %0d bad of %0d execs, want 0", bad, eq.size());
    end
  endtask

  task automatic test_run_gaps();
    bit ok;
    int bad;
    run_inf(1, 0, -1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_gaps_timeout: results=%0d, want %0d", res_q.size(), F_NUM);
    end
    bad = count_bad_seq(1, F_SIZE);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_gaps_exec: %0d bad of %0d execs, want 0", bad, eq.size());
    end
    bad = count_bad_results();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_gaps_result: %0d bad results, want 0", bad);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    run_inf(0, 0, 3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: results=%0d, want %0d", res_q.size(), F_NUM);
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, want 0", stall_err);
    end
    bad = count_bad_results();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_order: %0d bad results, want 0", bad);
    end
  endtask

  task automatic test_abort();
    bit ok1, ok2, ok3;
    int bad;
    int base;
    logic [7+AW+64-1:0] outs;
    stim_q.delete();
    for (int i = 0; i < F_SIZE; i++) stim_q.push_back(enc(act_i[i]));
    issue(OP_RUN);
    send_stream(0, 100, 0, ok1);
    rst_n = 1'b0;
    @(negedge clk);
    outs = {busy, done, s_ready, m_valid, dnn_write, dnn_init, dnn_exec, dnn_a, dnn_d, m_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got %h, want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    base = done_cnt;
    eq.delete();
    wq.delete();
    issue(OP_RUN);
    send_stream(0, 50, 0, ok1);
    start = 1'b1;
    op    = OP_LOAD;
    @(negedge clk);
    start = 1'b0;
    send_stream(50, F_SIZE, 0, ok2);
    collect(0, -1, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      errors++;
      $display("FAIL abort_timeout: results=%0d, want %0d", res_q.size(), F_NUM);
    end
    bad = count_bad_results();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_result: %0d bad, first=%h want %h", bad,
               (res_q.size() > 0) ? res_q[0] : 32'hx, expect_word(0));
    end
    wait_done(base + 1, ok1);
    checks++;
    if (!ok1 || wq.size() != 0 || count_bad_seq(1, F_SIZE) != 0) begin
      errors++;
      $display("FAIL abort_busy_start: done=%0d writes=%0d execs=%0d, want 1 0 %0d",
               done_cnt - base, wq.size(), eq.size(), F_SIZE);
    end
  endtask

  task automatic test_negative();
    bit ok;
    int bad;
    logic [31:0] want;
`ifdef TINY_DNN_SEQ_RELU_EN
    want = 32'h00000000;
`else
    want = 32'hC4800000;
`endif
    for (int i = 0; i < F_NUM*F_SIZE; i++) w_i[i] = -1;
    load_weights(0, ok);
    for (int i = 0; i < F_SIZE; i++) act_i[i] = 2;
    run_inf(0, 0, -1, ok);
    bad = 0;
    if (res_q.size() != F_NUM) bad = F_NUM;
    else foreach (res_q[i]) if (res_q[i] !== want) bad++;
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL negative_result: %0d bad, first=%h, want %h", bad,
               (res_q.size() > 0) ? res_q[0] : 32'hx, want);
    end
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    for (int i = 0; i < F_NUM*F_SIZE; i++) w_i[i] = int'($urandom_range(0, 4)) - 2;
    load_weights(2, ok);
    bad = count_bad_seq(0, F_NUM*F_SIZE);
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL random_load: ok=%0d bad=%0d, want 1 0", ok, bad);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < F_SIZE; i++) act_i[i] = int'($urandom_range(0, 4)) - 2;
      run_inf(2, 1, -1, ok);
      bad = count_bad_results();
      checks++;
      if (!ok || bad != 0) begin
        errors++;
        $display("FAIL random_run%0d: ok=%0d bad=%0d, first=%h want %h", r, ok, bad,
                 (res_q.size() > 0) ? res_q[0] : 32'hx, expect_word(0));
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (strobe_err != 0 || done_busy_err != 0 || idle_err != 0) begin
      errors++;
      $display("FAIL invariants: strobe=%0d done_busy=%0d idle=%0d, want 0 0 0",
               strobe_err, done_busy_err, idle_err);
    end
  endtask

  initial begin
    test_reset();
    test_load_ones();
    test_run_twos();
    test_run_gaps();
    test_stall();
    test_abort();
    test_negative();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
